// File: rtl/fft8_pkg.sv
// ---------------------------------------------------------------------------
// fft8_pkg
// Shared constants and types for the 8-point FFT core and its consumers.
//   - Complex word layout: [31:16] imaginary, [15:0] real, both signed Q8.8.
//   - Q8.8 twiddle constants used by the core's butterflies.
//   - Streamer FSM state encoding.
// ---------------------------------------------------------------------------
package fft8_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = DATA_W / 2;
    localparam int N_BINS = 8;
    localparam int IDX_W  = $clog2(N_BINS);
    localparam int MAG_W  = HALF_W + 1;

    // Field positions of the real and imaginary halves
    localparam int RE_LSB = 0;
    localparam int IM_LSB = HALF_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    // Q8.8 twiddles: 1.0 and +/- sqrt(2)/2 (181/256)
    localparam logic signed [HALF_W-1:0] TW_ONE    = 16'sh0100;
    localparam logic signed [HALF_W-1:0] TW_R2     = 16'sh00B5;
    localparam logic signed [HALF_W-1:0] TW_NEG_R2 = 16'shFF4B;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    function automatic logic signed [HALF_W-1:0] re_of(input logic [DATA_W-1:0] z);
        return z[RE_LSB +: HALF_W];
    endfunction

    function automatic logic signed [HALF_W-1:0] im_of(input logic [DATA_W-1:0] z);
        return z[IM_LSB +: HALF_W];
    endfunction

endpackage

// File: rtl/fft8_result_streamer_if.sv
// ---------------------------------------------------------------------------
// fft8_result_streamer_if
// Valid/ready bin stream produced by fft8_result_streamer.
//   out_valid  beat valid                (master -> slave)
//   out_ready  beat accepted             (slave  -> master)
//   out_data   complex bin, DATA_W       (master -> slave)
//   out_idx    bin index, IDX_W          (master -> slave)
//   out_last   final bin of the frame    (master -> slave)
//   out_magsq  re^2+im^2 of out_data, present only with FFT8_STREAM_MAGSQ_EN
// ---------------------------------------------------------------------------
interface fft8_result_streamer_if;
    import fft8_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
`ifdef FFT8_STREAM_MAGSQ_EN
    logic [31:0]       out_magsq;
`endif

    modport master (
`ifdef FFT8_STREAM_MAGSQ_EN
        output out_magsq,
`endif
        output out_valid, out_data, out_idx, out_last,
        input  out_ready
    );

    modport slave (
`ifdef FFT8_STREAM_MAGSQ_EN
        input  out_magsq,
`endif
        input  out_valid, out_data, out_idx, out_last,
        output out_ready
    );

endinterface

// File: rtl/fft8_result_streamer_cplx_l1_mag.sv
// ---------------------------------------------------------------------------
// cplx_l1_mag
// Combinational L1 magnitude |re| + |im| of one complex word.
//   z    in   DATA_W   complex word ({im, re}, signed halves)
//   mag  out  MAG_W    unsigned magnitude; one extra bit so |-32768| and the
//                      sum of two full-scale halves never saturate
// ---------------------------------------------------------------------------
module cplx_l1_mag
    import fft8_pkg::*;
(
    input  logic [DATA_W-1:0] z,
    output logic [MAG_W-1:0]  mag
);

    // Sign-extend before negating so the most negative value maps to +32768
    function automatic logic [MAG_W-1:0] abs_ext(input logic signed [HALF_W-1:0] v);
        logic signed [MAG_W-1:0] w;
        w = MAG_W'(v);
        return w[MAG_W-1] ? MAG_W'(-w) : MAG_W'(w);
    endfunction

    // Max sum is 0x8000 + 0x8000 = 0x10000, which fits in MAG_W bits
    assign mag = abs_ext(re_of(z)) + abs_ext(im_of(z));

endmodule

// File: rtl/fft8_result_streamer.sv
// ---------------------------------------------------------------------------
// fft8_result_streamer
// Captures the eight FFT bins on a rising edge of done_in and streams them
// out in order 0..7, one per accepted beat, tracking the peak L1-magnitude bin
// and counting completed frames.
//
// Ports:
//   clk         in   clock
//   reset_n     in   synchronous, active-low reset
//   done_in     in   FFT completion level; rising edge requests capture
//   bins_in     in   N_BINS*DATA_W flattened bins, bin k at [k*DATA_W +: DATA_W]
//   stream      if   fft8_result_streamer_if.master (valid/ready bin stream)
//   busy        out  high while streaming
//   overrun     out  sticky; a capture request was dropped mid-stream
//   peak_valid  out  one-cycle pulse after the last beat transfers
//   peak_idx    out  index of the largest-magnitude bin of the last frame
//   peak_mag    out  L1 magnitude of that bin
//   frame_cnt   out  completed frames, wraps
//
// Optional build macro FFT8_STREAM_MAGSQ_EN adds stream.out_magsq, the squared
// magnitude of out_data. Peak selection always uses the L1 magnitude.
// ---------------------------------------------------------------------------
module fft8_result_streamer
    import fft8_pkg::*;
#(
    parameter int FRAME_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      done_in,
    input  logic [N_BINS*DATA_W-1:0]  bins_in,
    fft8_result_streamer_if.master    stream,
    output logic                      busy,
    output logic                      overrun,
    output logic                      peak_valid,
    output logic [IDX_W-1:0]          peak_idx,
    output logic [MAG_W-1:0]          peak_mag,
    output logic [FRAME_CNT_W-1:0]    frame_cnt
);

    state_t            state;
    logic              done_q;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] bin_q [N_BINS];
    logic [IDX_W-1:0]  run_idx;
    logic [MAG_W-1:0]  run_mag;

    logic [DATA_W-1:0] cur_bin;
    logic [MAG_W-1:0]  beat_mag;
    logic              cap_edge;
    logic              xfer;
    logic              last_xfer;
    logic              capture;
    logic              take;
    logic [IDX_W-1:0]  fin_idx;
    logic [MAG_W-1:0]  fin_mag;

    assign cap_edge  = done_in && !done_q;
    assign busy      = (state == STREAM);
    assign xfer      = busy && stream.out_ready;
    assign last_xfer = xfer && (idx == LAST_IDX);
    // A capture is honoured in IDLE or exactly on the last-beat transfer
    assign capture   = cap_edge && ((state == IDLE) || last_xfer);

    assign cur_bin = bin_q[idx];

    cplx_l1_mag u_mag (
        .z   (cur_bin),
        .mag (beat_mag)
    );

    // Bin 0 always seeds the running peak; strict '>' keeps the lower index on ties
    assign take    = (idx == '0) || (beat_mag > run_mag);
    assign fin_idx = take ? idx      : run_idx;
    assign fin_mag = take ? beat_mag : run_mag;

    // Stale bin contents are masked while idle, so the bin file needs no reset
    assign stream.out_valid = busy;
    assign stream.out_data  = busy ? cur_bin : '0;
    assign stream.out_idx   = idx;
    assign stream.out_last  = busy && (idx == LAST_IDX);

`ifdef FFT8_STREAM_MAGSQ_EN
    logic signed [DATA_W-1:0] re_x;
    logic signed [DATA_W-1:0] im_x;
    logic signed [DATA_W-1:0] re_sq;
    logic signed [DATA_W-1:0] im_sq;

    // Each square is at most 2^30, so the unsigned sum fits in 32 bits
    assign re_x  = DATA_W'(re_of(stream.out_data));
    assign im_x  = DATA_W'(im_of(stream.out_data));
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;
    assign stream.out_magsq = $unsigned(re_sq) + $unsigned(im_sq);
`endif

    // Bin register file: loaded only on an accepted capture
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N_BINS; k++) begin
                bin_q[k] <= bins_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Control FSM and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            idx        <= '0;
            run_idx    <= '0;
            run_mag    <= '0;
            overrun    <= 1'b0;
            peak_valid <= 1'b0;
            peak_idx   <= '0;
            peak_mag   <= '0;
            frame_cnt  <= '0;
        end else begin
            done_q     <= done_in;
            peak_valid <= 1'b0;

            if (cap_edge && busy && !last_xfer) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (capture) begin
                        state   <= STREAM;
                        idx     <= '0;
                        run_idx <= '0;
                        run_mag <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        run_idx <= fin_idx;
                        run_mag <= fin_mag;
                        if (idx == LAST_IDX) begin
                            peak_valid <= 1'b1;
                            peak_idx   <= fin_idx;
                            peak_mag   <= fin_mag;
                            frame_cnt  <= frame_cnt + 1'b1;
                            idx        <= '0;
                            run_idx    <= '0;
                            run_mag    <= '0;
                            // Back-to-back frame keeps streaming from bin 0
                            state      <= capture ? STREAM : IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_result_streamer.sv
// ---------------------------------------------------------------------------
// tb_fft8_result_streamer
// Directed bench for fft8_result_streamer: ramp frame, tie rule, full-scale
// negative bin, backpressure, overrun, back-to-back capture, mid-stream reset
// and an edge on the first cycle after reset.
// ---------------------------------------------------------------------------
module tb_fft8_result_streamer;
    import fft8_pkg::*;

    logic                     clk;
    logic                     reset_n;
    logic                     done_in;
    logic [N_BINS*DATA_W-1:0] bins_in;
    logic                     busy;
    logic                     overrun;
    logic                     peak_valid;
    logic [IDX_W-1:0]         peak_idx;
    logic [MAG_W-1:0]         peak_mag;
    logic [15:0]              frame_cnt;

    fft8_result_streamer_if sif ();

    fft8_result_streamer #(.FRAME_CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .done_in    (done_in),
        .bins_in    (bins_in),
        .stream     (sif),
        .busy       (busy),
        .overrun    (overrun),
        .peak_valid (peak_valid),
        .peak_idx   (peak_idx),
        .peak_mag   (peak_mag),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] pat [N_BINS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N_BINS; k++) pat[k] = {16'h0000, 16'(k * 256)};
    endtask

    task automatic set_flat(input logic [31:0] v);
        for (int k = 0; k < N_BINS; k++) pat[k] = v;
    endtask

    task automatic apply_pat();
        for (int k = 0; k < N_BINS; k++) bins_in[k*DATA_W +: DATA_W] = pat[k];
    endtask

    // Start a frame: single-cycle done_in pulse, then confirm bin 0 is presented
    task automatic capture_frame();
        apply_pat();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        bins_in = {N_BINS{32'hDEAD_BEEF}};
        chk("cap_valid", 64'(sif.out_valid), 64'd1);
        chk("cap_idx", 64'(sif.out_idx), 64'd0);
    endtask

    // Beats first..last with out_ready high, one transfer per cycle
    task automatic stream_beats(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            chk("beat_valid", 64'(sif.out_valid), 64'd1);
            chk("beat_idx", 64'(sif.out_idx), 64'(k));
            chk("beat_data", 64'(sif.out_data), 64'(pat[k]));
            chk("beat_last", 64'(sif.out_last), (k == N_BINS - 1) ? 64'd1 : 64'd0);
            tick();
        end
    endtask

    task automatic check_done(input logic [IDX_W-1:0] e_idx, input logic [MAG_W-1:0] e_mag,
                              input logic [15:0] e_cnt);
        chk("peak_valid_hi", 64'(peak_valid), 64'd1);
        chk("peak_idx", 64'(peak_idx), 64'(e_idx));
        chk("peak_mag", 64'(peak_mag), 64'(e_mag));
        chk("frame_cnt", 64'(frame_cnt), 64'(e_cnt));
        chk("idle_valid", 64'(sif.out_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        tick();
        chk("peak_valid_lo", 64'(peak_valid), 64'd0);
        chk("peak_idx_hold", 64'(peak_idx), 64'(e_idx));
        chk("peak_mag_hold", 64'(peak_mag), 64'(e_mag));
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid", 64'(sif.out_valid), 64'd0);
        chk("rst_data", 64'(sif.out_data), 64'd0);
        chk("rst_idx", 64'(sif.out_idx), 64'd0);
        chk("rst_last", 64'(sif.out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_peak_valid", 64'(peak_valid), 64'd0);
        chk("rst_peak_idx", 64'(peak_idx), 64'd0);
        chk("rst_peak_mag", 64'(peak_mag), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        done_in       = 1'b0;
        sif.out_ready = 1'b1;
        bins_in       = '0;
        tick();
        tick();
        check_reset_outputs();
        reset_n = 1'b1;
        tick();
        chk("no_edge_idle", 64'(sif.out_valid), 64'd0);

        // Ramp frame; bins_in is scrambled after capture and must not matter
        set_ramp();
        capture_frame();
        stream_beats(0, 7);
        check_done(3'd7, 17'h00700, 16'd1);

        // Equal magnitudes: lowest index wins
        set_flat(32'h0001_0001);
        capture_frame();
        stream_beats(0, 7);
        check_done(3'd0, 17'd2, 16'd2);

        // Full-scale negative halves: |-32768|+|-32768| = 0x10000
        set_flat(32'h0010_0010);
        pat[3] = 32'h8000_8000;
        capture_frame();
        stream_beats(0, 7);
        check_done(3'd3, 17'h10000, 16'd3);

        // Backpressure at idx 2 for three cycles
        set_ramp();
        capture_frame();
        stream_beats(0, 1);
        sif.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_valid", 64'(sif.out_valid), 64'd1);
            chk("bp_idx", 64'(sif.out_idx), 64'd2);
            chk("bp_data", 64'(sif.out_data), 64'(pat[2]));
            chk("bp_last", 64'(sif.out_last), 64'd0);
        end
        sif.out_ready = 1'b1;
        stream_beats(2, 7);
        check_done(3'd7, 17'h00700, 16'd4);

        // Back-to-back capture exactly on the last-beat transfer
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        set_ramp();
        capture_frame();
        stream_beats(0, 6);
        chk("b2b_last_idx", 64'(sif.out_idx), 64'd7);
        chk("b2b_last_data", 64'(sif.out_data), 64'h0000_0700);
        set_flat(32'h0010_0010);
        pat[3] = 32'h8000_8000;
        apply_pat();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("b2b_peak_valid", 64'(peak_valid), 64'd1);
        chk("b2b_peak_idx", 64'(peak_idx), 64'd7);
        chk("b2b_peak_mag", 64'(peak_mag), 64'h700);
        chk("b2b_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("b2b_valid", 64'(sif.out_valid), 64'd1);
        chk("b2b_overrun", 64'(overrun), 64'd0);
        stream_beats(0, 7);
        check_done(3'd3, 17'h10000, 16'd2);
        chk("b2b_overrun_end", 64'(overrun), 64'd0);

        // Capture edge mid-stream is dropped and flags overrun
        set_ramp();
        capture_frame();
        stream_beats(0, 3);
        done_in = 1'b1;
        chk("ovr_pre_idx", 64'(sif.out_idx), 64'd4);
        tick();
        done_in = 1'b0;
        chk("ovr_flag", 64'(overrun), 64'd1);
        stream_beats(5, 7);
        check_done(3'd7, 17'h00700, 16'd3);
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Reset at idx 5 aborts the frame
        set_ramp();
        capture_frame();
        stream_beats(0, 4);
        reset_n = 1'b0;
        tick();
        check_reset_outputs();
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", 64'(sif.out_valid), 64'd0);
        chk("post_rst_no_peak", 64'(peak_valid), 64'd0);
        capture_frame();
        stream_beats(0, 7);
        check_done(3'd7, 17'h00700, 16'd1);

        // done_in already high when reset releases counts as an edge
        reset_n = 1'b0;
        done_in = 1'b1;
        apply_pat();
        tick();
        reset_n = 1'b1;
        tick();
        chk("first_cycle_edge_valid", 64'(sif.out_valid), 64'd1);
        chk("first_cycle_edge_idx", 64'(sif.out_idx), 64'd0);
        chk("first_cycle_edge_data", 64'(sif.out_data), 64'(pat[0]));
        done_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fft8_result_streamer.md
Name: fft8_result_streamer

Overview:
- Downstream consumer of the 8-point FFT core. Captures the eight parallel complex bins when the core signals completion, then streams them out one bin per beat, in natural order 0..7, over a valid/ready interface.
- While streaming, tracks the peak-magnitude bin and counts completed frames.
- Complex format matches the core: bits [31:16] are imaginary, bits [15:0] are real, both signed Q8.8.

Parameters:
- DATA_W, 32: complex word width (two signed halves of DATA_W/2).
- N_BINS, 8: number of bins per frame.
- IDX_W, 3: bin index width, equal to clog2(N_BINS).
- FRAME_CNT_W, 16: frame counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- done_in  in  1  FFT completion level; a rising edge requests capture
- bins_in  in  N_BINS*DATA_W  flattened bins; bin k is at [k*DATA_W +: DATA_W]
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  DATA_W  current bin
- out_idx  out  IDX_W  index of the current bin
- out_last  out  1  high when out_idx == N_BINS-1
- busy  out  1  high while in STREAM
- overrun  out  1  sticky; a capture request was dropped
- peak_valid  out  1  one-cycle pulse; peak result ready
- peak_idx  out  IDX_W  index of the largest-magnitude bin
- peak_mag  out  DATA_W/2+1  L1 magnitude of the peak bin
- frame_cnt  out  FRAME_CNT_W  completed frames, wraps

Behaviour:
- Reset is synchronous, active-low on reset_n; clock is clk.
- Reset values:
  - All outputs 0. The done_in edge-detect register is 0.
  - State is IDLE. Captured data is discarded.
  - Reset asserted mid-stream aborts the frame immediately. No peak_valid and no frame_cnt increment for that frame.
- Capture edge: done_in high while the registered previous value is low.
  - done_in already high at the first cycle after reset counts as an edge.
- States:
  - IDLE: on a capture edge, latch all bins_in into the bin register file and go to STREAM. Cleared at the same time: beat index, running peak (peak_idx and peak_mag internal copies).
  - STREAM: out_valid=1. out_data is bin[out_idx].
- Latency: edge sampled at cycle t, so out_valid=1 with out_idx=0 at cycle t+1.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - With out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
  - out_valid never drops before the transfer completes.
- On each transfer, compute L1 magnitude = |re| + |im| of the beat. It is unsigned, DATA_W/2+1 bits; |-32768| = 32768, with no saturation.
- The running peak updates only when the magnitude is strictly greater than the stored value, so ties keep the lower index. Bin 0 always loads the running peak.
- Last-beat transfer:
  - Next cycle: peak_valid=1 for one cycle. peak_idx and peak_mag take the final values and hold until the next frame's result.
  - frame_cnt increments, wrapping at 2^FRAME_CNT_W.
  - State returns to IDLE unless a back-to-back capture occurs (next rule).
- Capture edge in the same cycle as the last-beat transfer: accepted. Bins are relatched, state stays STREAM, and out_valid stays 1 with out_idx=0 on the next cycle. No overrun.
- Capture edge during STREAM at any other time: ignored and overrun set to 1. overrun clears only on reset.
- bins_in is sampled only at capture; later changes do not affect the stream.

Optional Feature:
- Macro: FFT8_STREAM_MAGSQ_EN.
- Defined: adds output port out_magsq (32 bits, unsigned) = re*re + im*im of out_data. It is combinational from the bin register and aligned with out_data, so it holds under backpressure.
- Peak selection still uses the L1 magnitude.
- Undefined: port and multipliers absent; all other behaviour identical.

Decomposition:
- Package fft8_pkg:
  - DATA_W, N_BINS, IDX_W.
  - Field slice constants for the re/im halves.
  - Q8.8 twiddle constants shared with the core.
  - State enum {IDLE, STREAM}.
- Sub-module cplx_l1_mag: combinational, takes a DATA_W complex input and produces the DATA_W/2+1 bit L1 magnitude.

Test Plan:
- Ramp frame, bin k = {16'h0000, k*16'h0100}, out_ready=1, done_in rises at t:
  - Beats 0..7 on cycles t+1..t+8; out_last at idx 7.
  - peak_valid at t+9 with peak_idx=7, peak_mag=17'h00700; frame_cnt=1.
- All bins 32'h0001_0001: peak_idx=0, peak_mag=2 (tie rule).
- bin3 = 32'h8000_8000, all others 32'h0010_0010: peak_idx=3, peak_mag=17'h10000.
- out_ready low during idx 2 for 3 cycles:
  - out_data, out_idx, out_last stable throughout.
  - 8 beats total, no duplicates, no skips.
- Edge at idx 4: overrun=1 and the stream completes unchanged. Edge exactly on the last-beat transfer: second frame follows immediately, overrun unaffected, frame_cnt=2.
- reset_n low at idx 5: next cycle all outputs 0 and state IDLE. A new edge restarts at idx 0.
